dense_argmax: RTL and testbench
===============================

Name: dense_argmax

Overview:
- Sits directly downstream of the final integer dense stage.
- Consumes its packed vector of B saturated signed 8-bit class scores, accompanied by a single-cycle valid pulse.
- Scans the scores sequentially, one comparison per cycle, and emits the winning class index and its score with a single-cycle valid pulse.
- Holds one pending vector so that back-to-back results from the dense stage are not lost.

Parameters:
- B, 7, number of classes / scores per vector; must be >= 2.
- DATA_WIDTH, 8, width of each signed score.
- IDX_WIDTH, clogb2(B-1), width of the class index (3 for B=7).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- valid_i  input  1  single-cycle strobe: data_i holds a complete score vector.
- data_i  input  DATA_WIDTH*B  packed signed scores; score k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- ready_o  output  1  high when a vector presented this cycle will be accepted (pending slot empty).
- valid_o  output  1  single-cycle pulse: class_o/max_o hold a new result.
- class_o  output  IDX_WIDTH  index of the maximum score.
- max_o  output  DATA_WIDTH  signed maximum score.
- ovf_o  output  1  sticky: a vector was dropped; cleared only by reset.

Behaviour:
- Reset (rstn low, asynchronous): all outputs and internal state cleared.
  - valid_o=0, class_o=0, max_o=0, ovf_o=0, ready_o=1.
  - FSM returns to IDLE; pending slot emptied.
  - A scan in progress is abandoned and no valid_o is produced for it.
- FSM states: IDLE, SCAN.
- IDLE, on valid_i:
  - Capture data_i into the work register.
  - best_val <= score0, best_idx <= 0, scan_idx <= 1.
  - Go to SCAN.
- SCAN, each cycle:
  - If signed score[scan_idx] > best_val (strict), take score[scan_idx] and scan_idx as the new best.
  - scan_idx increments by 1.
  - When scan_idx == B-1 is processed:
    - Register class_o and max_o from the final best (including this comparison).
    - Pulse valid_o for one cycle.
    - If the pending slot is full, move pending into the work register, reinitialise best to score0/idx 0/scan_idx 1, stay in SCAN, and empty the slot.
    - Otherwise go to IDLE.
- Latency: valid_o is high in the cycle after the (B-1)th clock edge following the capture edge, i.e. B-1 cycles after capture (6 for B=7). Throughput is one vector per B-1 cycles.
- Tie rule: the lowest index wins (strict greater-than).
- Comparisons are signed two's-complement, so -128 < -1 < 0 < 127.
- class_o and max_o hold their value until the next completion; they are not cleared when valid_o drops.
- valid_i while in SCAN:
  - If the pending slot is empty, capture into pending; ready_o drops the next cycle.
  - If the pending slot is full, drop the vector, set ovf_o, and leave pending unchanged.
- Simultaneous valid_i and final scan cycle with pending empty: the new vector goes directly to the work register. The scan restarts the next cycle with no bubble; pending stays empty.
- Simultaneous valid_i and final scan cycle with pending full: pending moves to the work register and the new vector is written into pending. Nothing is dropped and ovf_o is not set.
- ready_o = ~pending_full, registered. Upstream may ignore it; ovf_o records any loss.
- valid_i in IDLE is always accepted.

Test Plan:
- Reset then vector {s0..s6} = {3,-5,17,9,17,-128,0} at one valid_i pulse -> valid_o exactly 6 cycles later, class_o=2, max_o=17 (tie with s4 resolves to lower index).
- All scores -128 -> class_o=0, max_o=-128; all scores 127 -> class_o=0, max_o=127; vector {-1,-2,-3,-4,-5,-6,-7} -> class_o=0, max_o=-1.
- Max in last slot {0,0,0,0,0,0,5} -> class_o=6, max_o=5; then a second vector pulsed 2 cycles after the first -> ready_o low one cycle later; two valid_o pulses 6 cycles apart with correct results for each; ovf_o stays 0.
- Three vectors pulsed on consecutive cycles -> first two produce results; third dropped; ovf_o=1 and remains 1 until rstn.
- Vector V2 pulsed exactly in the final scan cycle of V1 (pending empty) -> V2 result 6 cycles after V1 result; no drop.
- rstn pulsed low mid-scan (cycle 3 of 6) -> outputs immediately 0, ready_o=1, no valid_o for the aborted vector; a fresh vector after release produces the correct result.

Source files
------------

// File: rtl/dense_argmax_if.sv
// dense_argmax_if
// Bundles the upstream score-vector handshake and the downstream result
// signals of dense_argmax.
//   valid_i  single-cycle strobe, data_i holds a full score vector
//   data_i   B packed signed scores, score k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ready_o  pending slot empty (a vector offered now will be kept)
//   valid_o  single-cycle pulse, class_o/max_o carry a new result
//   class_o  index of the winning score
//   max_o    winning signed score
//   ovf_o    sticky flag, some vector was dropped
// Modports: slave = the argmax block, master = the upstream/downstream side.
interface dense_argmax_if #(
    parameter int B          = 7,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = $clog2(B)
);
    logic                    valid_i;
    logic [DATA_WIDTH*B-1:0] data_i;
    logic                    ready_o;
    logic                    valid_o;
    logic [IDX_WIDTH-1:0]    class_o;
    logic [DATA_WIDTH-1:0]   max_o;
    logic                    ovf_o;

    modport slave (
        input  valid_i, data_i,
        output ready_o, valid_o, class_o, max_o, ovf_o
    );

    modport master (
        output valid_i, data_i,
        input  ready_o, valid_o, class_o, max_o, ovf_o
    );
endinterface

// File: rtl/dense_argmax.sv
// dense_argmax
// Sequential argmax over a packed vector of B signed scores. One comparison
// per cycle; the result appears B-1 cycles after the vector is captured.
// A single pending slot absorbs one vector arriving while a scan runs;
// anything beyond that is dropped and recorded in the sticky ovf_o.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   dense_argmax_if.slave (valid_i/data_i in, ready_o/valid_o/
//         class_o/max_o/ovf_o out)
module dense_argmax #(
    parameter int B          = 7,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = $clog2(B)
) (
    input  logic         clk,
    input  logic         rstn,
    dense_argmax_if.slave bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(B - 1);

    logic [0:0]                   state_reg;
    logic [DATA_WIDTH*B-1:0]      work_reg;
    logic [DATA_WIDTH*B-1:0]      pending_reg;
    logic                         pending_full_reg;
    logic signed [DATA_WIDTH-1:0] best_val_reg;
    logic [IDX_WIDTH-1:0]         best_idx_reg;
    logic [IDX_WIDTH-1:0]         scan_idx_reg;
    logic                         valid_reg;
    logic [IDX_WIDTH-1:0]         class_reg;
    logic signed [DATA_WIDTH-1:0] max_reg;
    logic                         ovf_reg;

    // Unpacked view of the work vector so the scan can index by score.
    logic signed [DATA_WIDTH-1:0] work_score [B];

    genvar gi;
    generate
        for (gi = 0; gi < B; gi++) begin : g_unpack
            assign work_score[gi] = $signed(work_reg[gi*DATA_WIDTH +: DATA_WIDTH]);
        end
    endgenerate

    logic signed [DATA_WIDTH-1:0] cur_score;
    logic                         take_cur;
    logic                         last_step;
    logic signed [DATA_WIDTH-1:0] best_val_next;
    logic [IDX_WIDTH-1:0]         best_idx_next;
    logic                         load_en;
    logic [DATA_WIDTH*B-1:0]      load_vec;

    always_comb begin
        cur_score = work_score[scan_idx_reg];
        // Strict compare keeps the lowest index on ties.
        take_cur  = (cur_score > best_val_reg);
        last_step = (state_reg == ST_SCAN) && (scan_idx_reg == LAST_IDX);
        best_val_next = take_cur ? cur_score    : best_val_reg;
        best_idx_next = take_cur ? scan_idx_reg : best_idx_reg;

        // A new scan starts from IDLE on valid_i, or back-to-back at the end
        // of a scan: the pending vector has priority over a fresh one.
        load_en  = 1'b0;
        load_vec = bus.data_i;
        if (state_reg == ST_IDLE) begin
            load_en = bus.valid_i;
        end else if (last_step) begin
            if (pending_full_reg) begin
                load_en  = 1'b1;
                load_vec = pending_reg;
            end else begin
                load_en = bus.valid_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= ST_IDLE;
            work_reg         <= '0;
            pending_reg      <= '0;
            pending_full_reg <= 1'b0;
            best_val_reg     <= '0;
            best_idx_reg     <= '0;
            scan_idx_reg     <= '0;
            valid_reg        <= 1'b0;
            class_reg        <= '0;
            max_reg          <= '0;
            ovf_reg          <= 1'b0;
        end else begin
            valid_reg <= 1'b0;

            if (last_step) begin
                class_reg <= best_idx_next;
                max_reg   <= best_val_next;
                valid_reg <= 1'b1;
            end

            if (load_en) begin
                state_reg    <= ST_SCAN;
                work_reg     <= load_vec;
                best_val_reg <= $signed(load_vec[DATA_WIDTH-1:0]);
                best_idx_reg <= '0;
                scan_idx_reg <= IDX_WIDTH'(1);
            end else if (last_step) begin
                state_reg <= ST_IDLE;
            end else if (state_reg == ST_SCAN) begin
                best_val_reg <= best_val_next;
                best_idx_reg <= best_idx_next;
                scan_idx_reg <= scan_idx_reg + 1'b1;
            end

            // Pending slot: only relevant while scanning. On the last step a
            // full slot drains into work and may be refilled in the same edge.
            if (state_reg == ST_SCAN && bus.valid_i) begin
                if (last_step) begin
                    if (pending_full_reg) begin
                        pending_reg <= bus.data_i;
                    end
                end else if (pending_full_reg) begin
                    ovf_reg <= 1'b1;
                end else begin
                    pending_reg      <= bus.data_i;
                    pending_full_reg <= 1'b1;
                end
            end else if (last_step && pending_full_reg) begin
                pending_full_reg <= 1'b0;
            end
        end
    end

    assign bus.ready_o = ~pending_full_reg;
    assign bus.valid_o = valid_reg;
    assign bus.class_o = class_reg;
    assign bus.max_o   = max_reg;
    assign bus.ovf_o   = ovf_reg;
endmodule

// File: tb/tb_dense_argmax.sv
// tb_dense_argmax
// Scoreboard bench for dense_argmax: the driver predicts acceptance/drop and
// completion time of each vector from a queueing view of the block
// (one vector in service for B-1 cycles, at most one waiting) and pushes the
// expected argmax result; a monitor pops on every valid_o.
module tb_dense_argmax;
    localparam int B  = 7;
    localparam int DW = 8;
    localparam int IW = $clog2(B);
    localparam int LAT = B - 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;

    dense_argmax_if #(.B(B), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    dense_argmax #(.B(B), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cls;
        int mx;
        int due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_ovf = 0;
    int   have_prev = 0;
    int   last_start = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW*B-1:0] pack(input int s[B]);
        logic [DW*B-1:0] v;
        v = '0;
        for (int k = 0; k < B; k++) v[k*DW +: DW] = DW'(s[k]);
        return v;
    endfunction

    // Drive one valid_i pulse (cleared by the next send/idle call).
    task automatic send(input int s[B]);
        int t;
        int best;
        int bidx;
        exp_t e;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.data_i  = pack(s);
        t = cyc + 1;  // edge that samples this pulse
        if (have_prev != 0 && last_start > t) begin
            exp_ovf = 1;  // one already waiting: this one is lost
        end else begin
            if (have_prev != 0 && last_start + LAT > t) last_start = last_start + LAT;
            else last_start = t;
            have_prev = 1;
            best = s[0];
            bidx = 0;
            for (int k = 1; k < B; k++) begin
                if (s[k] > best) begin
                    best = s[k];
                    bidx = k;
                end
            end
            e.cls = bidx;
            e.mx  = best;
            e.due = last_start + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.valid_i = 1'b0;
        rstn = 1'b0;
        sb.delete();
        have_prev = 0;
        exp_ovf = 0;
        #1;
        check("rst_valid_o", int'(bus.valid_o), 0);
        check("rst_class_o", int'(bus.class_o), 0);
        check("rst_max_o",   int'($signed(bus.max_o)), 0);
        check("rst_ready_o", int'(bus.ready_o), 1);
        check("rst_ovf_o",   int'(bus.ovf_o), 0);
        idle(2);
        rstn = 1'b1;
    endtask

    // Monitor: every valid_o must match the oldest expected result on time.
    always @(negedge clk) begin
        if (rstn && bus.valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_valid_o", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("class_o", int'(bus.class_o), e.cls);
                check("max_o", int'($signed(bus.max_o)), e.mx);
                check("latency_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        int v[B];
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        idle(2);
        rstn = 1'b1;
        idle(1);
        check("init_ready_o", int'(bus.ready_o), 1);
        check("init_valid_o", int'(bus.valid_o), 0);
        check("init_ovf_o",   int'(bus.ovf_o), 0);

        // Basic vector with a tie at index 2 and 4.
        v = '{3, -5, 17, 9, 17, -128, 0};
        send(v);
        drain();

        // Extremes.
        v = '{-128, -128, -128, -128, -128, -128, -128};
        send(v);
        drain();
        v = '{127, 127, 127, 127, 127, 127, 127};
        send(v);
        drain();
        v = '{-1, -2, -3, -4, -5, -6, -7};
        send(v);
        drain();

        // Max in last slot, second vector 2 cycles later goes to pending.
        v = '{0, 0, 0, 0, 0, 0, 5};
        send(v);
        idle(1);
        v = '{10, 20, -30, 20, 0, 1, 2};
        send(v);
        idle(1);
        check("ready_low_after_pending", int'(bus.ready_o), 0);
        drain();
        check("ready_after_drain", int'(bus.ready_o), 1);
        check("ovf_after_pending", int'(bus.ovf_o), exp_ovf);

        // Second vector exactly in the final scan cycle of the first.
        v = '{1, 2, 3, 4, 5, 6, 7};
        send(v);
        idle(LAT - 1);
        v = '{-9, -3, -3, -50, -4, -100, -3};
        send(v);
        drain();
        check("ovf_final_cycle", int'(bus.ovf_o), exp_ovf);

        // Three consecutive vectors: third is dropped.
        v = '{5, 4, 3, 2, 1, 0, -1};
        send(v);
        v = '{0, 0, 9, 0, 0, 0, 0};
        send(v);
        v = '{0, 0, 0, 0, 0, 99, 0};
        send(v);
        drain();
        check("ovf_after_drop", int'(bus.ovf_o), 1);
        v = '{2, 2, 2, 2, 2, 2, 3};
        send(v);
        drain();
        check("ovf_sticky", int'(bus.ovf_o), 1);

        // Abort mid-scan with reset, then a fresh vector.
        v = '{0, 0, 0, 44, 0, 0, 0};
        send(v);
        idle(2);
        do_reset();
        idle(LAT + 2);  // any late valid_o for the aborted vector is unexpected
        v = '{-7, 8, -9, 10, -11, 12, -13};
        send(v);
        drain();
        check("ovf_after_reset", int'(bus.ovf_o), 0);

        // Randomised traffic with random gaps (including back-to-back).
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < B; k++) begin
                case ($urandom_range(0, 5))
                    0: v[k] = -128;
                    1: v[k] = 127;
                    2: v[k] = int'($urandom_range(0, 3)) - 2;
                    default: v[k] = int'($urandom_range(0, 255)) - 128;
                endcase
            end
            send(v);
            idle(int'($urandom_range(0, 8)));
        end
        drain();
        check("ovf_random", int'(bus.ovf_o), exp_ovf);
        check("ready_final", int'(bus.ready_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
